// File: rtl/mul_div_unit.sv
// rtl/mul_div_unit.sv - iterative MIPS mult/multu/div/divu unit holding architectural HI/LO
// Iterates on operand magnitudes one radix-2 step per cycle; signs are applied in FIN.
module mul_div_unit #(
   parameter int WIDTH = 32,
   parameter int CNT_W = 6
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [1:0]       mdOp,
   input  logic [WIDTH-1:0] inA,
   input  logic [WIDTH-1:0] inB,
   input  logic             hiWe,
   input  logic             loWe,
   input  logic [WIDTH-1:0] wrData,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] hi,
   output logic [WIDTH-1:0] lo
);
   typedef enum logic [1:0] {IDLE, RUN, FIN} state_t;

   state_t             state;
   logic [CNT_W-1:0]   count;
   logic               is_div, neg_q, neg_r, div_zero;
   logic [WIDTH-1:0]   mag_b, acc, qr;

   logic               sign_a, sign_b;
   logic [WIDTH-1:0]   abs_a, abs_b;
   logic [WIDTH:0]     mul_sum, div_sh;
   logic               div_ok;
   logic [WIDTH-1:0]   div_diff;
   logic [2*WIDTH-1:0] prod_fix;
   logic [WIDTH-1:0]   quot_fix, rem_fix;

   // acc/qr act as {upper, lower} product halves for multiply and as {remainder, quotient} for divide
   always_comb begin
      sign_a   = ~mdOp[0] & inA[WIDTH-1];
      sign_b   = ~mdOp[0] & inB[WIDTH-1];
      abs_a    = sign_a ? -inA : inA;
      abs_b    = sign_b ? -inB : inB;
      mul_sum  = {1'b0, acc} + (qr[0] ? {1'b0, mag_b} : '0);
      div_sh   = {acc, qr[WIDTH-1]};
      div_ok   = div_sh >= {1'b0, mag_b};
      div_diff = div_sh[WIDTH-1:0] - mag_b;
      prod_fix = neg_q ? -{acc, qr} : {acc, qr};
      quot_fix = neg_q ? -qr : qr;
      rem_fix  = neg_r ? -acc : acc;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state    <= IDLE;
         busy     <= 1'b0;
         done     <= 1'b0;
         hi       <= '0;
         lo       <= '0;
         count    <= '0;
         is_div   <= 1'b0;
         neg_q    <= 1'b0;
         neg_r    <= 1'b0;
         div_zero <= 1'b0;
         mag_b    <= '0;
         acc      <= '0;
         qr       <= '0;
      end else begin
         done <= 1'b0;
         case (state)
            IDLE: begin
               if (start) begin
                  is_div   <= mdOp[1];
                  neg_q    <= sign_a ^ sign_b;
                  neg_r    <= sign_a;
                  div_zero <= mdOp[1] && (inB == '0);
                  mag_b    <= abs_b;
                  acc      <= '0;
                  qr       <= abs_a;
                  count    <= '0;
                  busy     <= 1'b1;
                  state    <= RUN;
               end else begin
                  if (hiWe) hi <= wrData;
                  if (loWe) lo <= wrData;
               end
            end
            RUN: begin
               if (is_div) begin
                  acc <= div_ok ? div_diff : div_sh[WIDTH-1:0];
                  qr  <= {qr[WIDTH-2:0], div_ok};
               end else begin
                  acc <= mul_sum[WIDTH:1];
                  qr  <= {mul_sum[0], qr[WIDTH-1:1]};
               end
               count <= count + 1'b1;
               if (count == CNT_W'(WIDTH - 1)) state <= FIN;
            end
            FIN: begin
               // a zero divisor leaves |inA| in acc, so the remainder path restores inA
               if (is_div) begin
                  hi <= rem_fix;
                  lo <= div_zero ? '1 : quot_fix;
               end else begin
                  {hi, lo} <= prod_fix;
               end
               busy  <= 1'b0;
               done  <= 1'b1;
               state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_mul_div_unit.sv
// tb/tb_mul_div_unit.sv - randomized self-checking bench for mul_div_unit
// Expected HI/LO come from plain 64-bit arithmetic on the architectural operation.
module tb_mul_div_unit;
   localparam int W = 32;

   logic         clk = 1'b0;
   logic         rst, start, hiWe, loWe, busy, done;
   logic [1:0]   mdOp;
   logic [W-1:0] inA, inB, wrData, hi, lo;
   int           total = 0;
   int           bad = 0;

   always #5 clk = ~clk;

   mul_div_unit #(.WIDTH(W), .CNT_W(6)) dut (
      .clk(clk), .rst(rst), .start(start), .mdOp(mdOp), .inA(inA), .inB(inB),
      .hiWe(hiWe), .loWe(loWe), .wrData(wrData), .busy(busy), .done(done),
      .hi(hi), .lo(lo)
   );

   task automatic model(input logic [1:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                        output logic [W-1:0] eh, output logic [W-1:0] el);
      logic [2*W-1:0] p;
      longint         q, r;
      p = '0;
      q = 0;
      r = 0;
      if (op == 2'b00) p = longint'($signed(a)) * longint'($signed(b));
      else if (op == 2'b01) p = {32'b0, a} * {32'b0, b};
      if (op[1] == 1'b0) begin
         eh = p[2*W-1:W];
         el = p[W-1:0];
      end else if (b == '0) begin
         eh = a;
         el = '1;
      end else if (op == 2'b10) begin
         q  = longint'($signed(a)) / longint'($signed(b));
         r  = longint'($signed(a)) % longint'($signed(b));
         eh = r[W-1:0];
         el = q[W-1:0];
      end else begin
         eh = a % b;
         el = a / b;
      end
   endtask

   // Caller is at a negedge; returns at the negedge of the done cycle (or after the bound).
   task automatic run_op(input logic [1:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                         input bit disturb, output int lat, output bit busy_ok, output bit hold_ok,
                         output logic [W-1:0] h, output logic [W-1:0] l);
      logic [W-1:0] h0, l0;
      h0 = hi;
      l0 = lo;
      start = 1'b1; mdOp = op; inA = a; inB = b;
      @(posedge clk);
      @(negedge clk);
      start = 1'b0; hiWe = 1'b0; loWe = 1'b0;
      mdOp = 2'($urandom); inA = $urandom; inB = $urandom;
      lat = 1; busy_ok = 1'b1; hold_ok = 1'b1;
      while (done !== 1'b1 && lat < 40) begin
         if (busy !== 1'b1) busy_ok = 1'b0;
         if (hi !== h0 || lo !== l0) hold_ok = 1'b0;
         if (disturb && lat == 5) begin
            start = 1'b1; hiWe = 1'b1; loWe = 1'b1; wrData = $urandom;
            mdOp = 2'($urandom); inA = $urandom; inB = $urandom;
         end else begin
            start = 1'b0; hiWe = 1'b0; loWe = 1'b0;
         end
         @(negedge clk);
         lat++;
      end
      if (busy !== 1'b0) busy_ok = 1'b0;
      h = hi;
      l = lo;
   endtask

   task automatic test_reset();
      rst = 1'b1; start = 1'b0; hiWe = 1'b0; loWe = 1'b0; mdOp = 2'b00;
      inA = '0; inB = '0; wrData = '0;
      repeat (2) @(negedge clk);
      total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy: got %b required 0", busy); end
      total++; if (done !== 1'b0) begin bad++; $display("FAIL reset_done: got %b required 0", done); end
      total++; if (hi !== '0) begin bad++; $display("FAIL reset_hi: got %h required 0", hi); end
      total++; if (lo !== '0) begin bad++; $display("FAIL reset_lo: got %h required 0", lo); end
      rst = 1'b0;
   endtask

   task automatic test_mul_unsigned();
      logic [W-1:0] a, b, eh, el, h, l;
      int lat; bit bok, hok;
      for (int i = 0; i < 7; i++) begin
         if (i == 0) begin a = 32'hFFFF_FFFF; b = 32'hFFFF_FFFF; end
         else begin a = $urandom; b = $urandom; end
         model(2'b01, a, b, eh, el);
         run_op(2'b01, a, b, 1'b0, lat, bok, hok, h, l);
         total++;
         if (lat != W + 2 || !bok || !hok) begin
            bad++; $display("FAIL multu_timing[%0d]: lat=%0d busy_ok=%0b hold_ok=%0b, required lat=%0d 1 1", i, lat, bok, hok, W + 2);
         end
         total++;
         if (h !== eh || l !== el) begin
            bad++; $display("FAIL multu_result[%0d] %h*%h: got %h_%h required %h_%h", i, a, b, h, l, eh, el);
         end
      end
   endtask

   task automatic test_mul_signed();
      logic [W-1:0] a, b, eh, el, h, l;
      int lat; bit bok, hok;
      for (int i = 0; i < 8; i++) begin
         case (i)
            0: begin a = 32'hFFFF_FFFD; b = 32'd5; end
            1: begin a = 32'h8000_0000; b = 32'h8000_0000; end
            2: begin a = 32'h7FFF_FFFF; b = 32'h8000_0000; end
            default: begin a = $urandom; b = $urandom; end
         endcase
         model(2'b00, a, b, eh, el);
         run_op(2'b00, a, b, 1'b0, lat, bok, hok, h, l);
         total++;
         if (lat != W + 2 || !bok || !hok) begin
            bad++; $display("FAIL mult_timing[%0d]: lat=%0d busy_ok=%0b hold_ok=%0b, required lat=%0d 1 1", i, lat, bok, hok, W + 2);
         end
         total++;
         if (h !== eh || l !== el) begin
            bad++; $display("FAIL mult_result[%0d] %h*%h: got %h_%h required %h_%h", i, a, b, h, l, eh, el);
         end
      end
   endtask

   task automatic test_divide();
      logic [W-1:0] a, b, eh, el, h, l;
      logic [1:0] op;
      int lat; bit bok, hok;
      for (int i = 0; i < 14; i++) begin
         op = (i < 3 || i[0]) ? 2'b10 : 2'b11;
         case (i)
            0: begin a = 32'hFFFF_FFF9; b = 32'd2; end
            1: begin a = 32'd7; b = 32'hFFFF_FFFE; end
            2: begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
            default: begin
               a = $urandom;
               b = ($urandom_range(0, 1) == 0) ? 32'($urandom_range(1, 300)) : $urandom;
               if (b == '0) b = 32'd1;
            end
         endcase
         model(op, a, b, eh, el);
         run_op(op, a, b, 1'b0, lat, bok, hok, h, l);
         total++;
         if (lat != W + 2 || !bok || !hok) begin
            bad++; $display("FAIL div_timing[%0d]: lat=%0d busy_ok=%0b hold_ok=%0b, required lat=%0d 1 1", i, lat, bok, hok, W + 2);
         end
         total++;
         if (h !== eh || l !== el) begin
            bad++; $display("FAIL div_result[%0d] op=%0d %h/%h: got hi=%h lo=%h required hi=%h lo=%h", i, op, a, b, h, l, eh, el);
         end
      end
   endtask

   task automatic test_div_zero();
      logic [W-1:0] a, h, l;
      logic [1:0] op;
      int lat; bit bok, hok;
      for (int i = 0; i < 5; i++) begin
         case (i)
            0: begin op = 2'b11; a = 32'd100; end
            1: begin op = 2'b10; a = 32'hFFFF_FFFB; end
            2: begin op = 2'b10; a = 32'h8000_0000; end
            default: begin op = {1'b1, 1'($urandom)}; a = $urandom; end
         endcase
         run_op(op, a, '0, 1'b0, lat, bok, hok, h, l);
         total++;
         if (lat != W + 2 || !bok || !hok) begin
            bad++; $display("FAIL divzero_timing[%0d]: lat=%0d busy_ok=%0b hold_ok=%0b, required lat=%0d 1 1", i, lat, bok, hok, W + 2);
         end
         total++;
         if (h !== a || l !== 32'hFFFF_FFFF) begin
            bad++; $display("FAIL divzero_result[%0d] op=%0d a=%h: got hi=%h lo=%h required hi=%h lo=ffffffff", i, op, a, h, l, a);
         end
      end
   endtask

   task automatic test_handshake();
      logic [W-1:0] a, b, eh, el, h, l;
      int lat; bit bok, hok;
      a = $urandom; b = $urandom;
      model(2'b01, a, b, eh, el);
      run_op(2'b01, a, b, 1'b1, lat, bok, hok, h, l);
      total++;
      if (!hok || !bok || lat != W + 2) begin
         bad++; $display("FAIL busy_ignore_timing: lat=%0d busy_ok=%0b hold_ok=%0b, required lat=%0d 1 1", lat, bok, hok, W + 2);
      end
      total++;
      if (h !== eh || l !== el) begin
         bad++; $display("FAIL busy_ignore_result: got %h_%h required %h_%h", h, l, eh, el);
      end
      // start issued with mthi/mtlo in the same cycle, back-to-back in the done cycle
      a = $urandom; b = 32'($urandom_range(1, 1000));
      model(2'b11, a, b, eh, el);
      hiWe = 1'b1; loWe = 1'b1; wrData = 32'hDEAD_BEEF;
      run_op(2'b11, a, b, 1'b0, lat, bok, hok, h, l);
      total++;
      if (!hok) begin bad++; $display("FAIL start_beats_write: hold_ok=%0b required 1", hok); end
      total++;
      if (lat != W + 2 || h !== eh || l !== el) begin
         bad++; $display("FAIL start_beats_write_result: lat=%0d hi=%h lo=%h required lat=%0d hi=%h lo=%h", lat, h, l, W + 2, eh, el);
      end
   endtask

   task automatic test_back_to_back();
      logic [W-1:0] a, b, eh, el, h, l;
      logic [1:0] op;
      int lat; bit bok, hok;
      for (int i = 0; i < 16; i++) begin
         op = 2'($urandom);
         a = $urandom;
         b = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 20)) : $urandom;
         model(op, a, b, eh, el);
         run_op(op, a, b, 1'b0, lat, bok, hok, h, l);
         total++;
         if (lat != W + 2 || !bok || !hok || h !== eh || l !== el) begin
            bad++; $display("FAIL b2b[%0d] op=%0d %h,%h: lat=%0d busy_ok=%0b hold_ok=%0b hi=%h lo=%h required lat=%0d hi=%h lo=%h",
                            i, op, a, b, lat, bok, hok, h, l, W + 2, eh, el);
         end
      end
   endtask

   task automatic test_reset_mid_and_mtx();
      logic [W-1:0] d;
      bit late_done;
      start = 1'b1; mdOp = 2'b10; inA = 32'd12345; inB = 32'd7;
      @(posedge clk);
      @(negedge clk);
      start = 1'b0;
      for (int c = 1; c < 10; c++) @(negedge clk);
      rst = 1'b1;
      @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
      total++; if (busy !== 1'b0) begin bad++; $display("FAIL midrst_busy: got %b required 0", busy); end
      total++; if (done !== 1'b0) begin bad++; $display("FAIL midrst_done: got %b required 0", done); end
      total++; if (hi !== '0 || lo !== '0) begin bad++; $display("FAIL midrst_hilo: got %h_%h required 0_0", hi, lo); end
      late_done = 1'b0;
      for (int c = 0; c < 40; c++) begin
         if (done !== 1'b0 || busy !== 1'b0) late_done = 1'b1;
         @(negedge clk);
      end
      total++; if (late_done) begin bad++; $display("FAIL midrst_late_done: saw activity, required none"); end
      hiWe = 1'b1; wrData = 32'h1234;
      @(posedge clk); @(negedge clk);
      hiWe = 1'b0;
      total++; if (hi !== 32'h1234 || lo !== '0) begin bad++; $display("FAIL mthi: got hi=%h lo=%h required 1234 0", hi, lo); end
      loWe = 1'b1; wrData = 32'h5678;
      @(posedge clk); @(negedge clk);
      loWe = 1'b0;
      total++; if (hi !== 32'h1234 || lo !== 32'h5678) begin bad++; $display("FAIL mtlo: got hi=%h lo=%h required 1234 5678", hi, lo); end
      d = $urandom;
      hiWe = 1'b1; loWe = 1'b1; wrData = d;
      @(posedge clk); @(negedge clk);
      hiWe = 1'b0; loWe = 1'b0;
      total++; if (hi !== d || lo !== d) begin bad++; $display("FAIL mthi_mtlo_both: got hi=%h lo=%h required %h", hi, lo, d); end
   endtask

   initial begin
      test_reset();
      test_mul_unsigned();
      test_mul_signed();
      test_divide();
      test_div_zero();
      test_handshake();
      test_back_to_back();
      test_reset_mid_and_mtx();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
